// File: rtl/bypass_rd_rsp_tracker.sv
// Bypass read-response tracker: forwards rq_rd requests, remembers them, and matches tagged user
// read-response beats to the oldest one. Define BYPASS_RSP_KEEP_MASK_EN to trim tkeep on final beats.
module bypass_rd_rsp_tracker #(
    parameter int DATA_BITS = 512,
    parameter int VFID_BITS = 4,
    parameter int DEST_BITS = 4,
    parameter int LEN_BITS  = 28,
    parameter int DEPTH     = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_rq_valid,
    output logic                     s_rq_ready,
    input  logic [VFID_BITS-1:0]     s_rq_vfid,
    input  logic [LEN_BITS-1:0]      s_rq_len,
    input  logic [DEST_BITS-1:0]     s_rq_dest,
    output logic                     m_rq_valid,
    input  logic                     m_rq_ready,
    output logic [VFID_BITS-1:0]     m_rq_vfid,
    output logic [LEN_BITS-1:0]      m_rq_len,
    output logic [DEST_BITS-1:0]     m_rq_dest,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DATA_BITS-1:0]     s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]   s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [VFID_BITS-1:0]     s_axis_tid,
    input  logic [DEST_BITS-1:0]     s_axis_tdest,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_BITS-1:0]     m_axis_tdata,
    output logic [DATA_BITS/8-1:0]   m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [31:0]              drop_cnt,
    output logic [31:0]              short_cnt
);
    // state  | meaning
    // IDLE   | no head loaded; pops the oldest request when the FIFO is non-empty
    // STREAM | head loaded; matching beats forwarded, mismatching tid diverts to DROP
    // DROP   | discarding beats until user tlast; resumes STREAM if a head is still loaded

    localparam int BPB       = DATA_BITS / 8;
    localparam int OFF_BITS  = $clog2(BPB);
    localparam int BEAT_BITS = LEN_BITS + 1 - OFF_BITS;
    localparam int PTR_BITS  = $clog2(DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t                 state, state_nxt;
    logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]    count;
    logic                   full, empty, rq_ok, push, pop;
    logic [BEAT_BITS-1:0]   rq_beats;
    logic [VFID_BITS-1:0]   fifo_vfid  [DEPTH];
    logic [BEAT_BITS-1:0]   fifo_beats [DEPTH];
    logic                   hvalid;
    logic [VFID_BITS-1:0]   hvfid;
    logic [BEAT_BITS-1:0]   rem;
    logic                   beat, tid_ok, fwd, drop, last_beat, retire, short_rsp;
    logic [BPB-1:0]         keep_out;
    logic                   unused_tdest;

    assign unused_tdest = ^s_axis_tdest;

    assign full  = (count == CNT_BITS'(DEPTH));
    assign empty = (count == '0);

    // Zero-length requests never occupy a slot, so they bypass the full check.
    assign rq_ok      = !full || (s_rq_len == '0);
    assign m_rq_valid = !areset && s_rq_valid && rq_ok;
    assign s_rq_ready = !areset && m_rq_ready && rq_ok;
    assign m_rq_vfid  = s_rq_vfid;
    assign m_rq_len   = s_rq_len;
    assign m_rq_dest  = s_rq_dest;

    assign push     = s_rq_valid && s_rq_ready && (s_rq_len != '0);
    assign rq_beats = BEAT_BITS'(({1'b0, s_rq_len} + (LEN_BITS+1)'(BPB - 1)) >> OFF_BITS);

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_vfid[wr_ptr]  <= s_rq_vfid;
            fifo_beats[wr_ptr] <= rq_beats;
        end
    end

    assign beat      = s_axis_tvalid && s_axis_tready;
    assign tid_ok    = (s_axis_tid == hvfid);
    assign fwd       = beat && (state == STREAM) && tid_ok;
    assign drop      = beat && ((state == DROP) || ((state == STREAM) && !tid_ok));
    assign last_beat = (rem == BEAT_BITS'(1));
    assign retire    = fwd && (last_beat || s_axis_tlast);
    assign short_rsp = fwd && s_axis_tlast && !last_beat;

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!empty) state_nxt = STREAM;
            STREAM: begin
                if (fwd) begin
                    if (last_beat && !s_axis_tlast)       state_nxt = DROP;
                    else if (last_beat || s_axis_tlast)   state_nxt = IDLE;
                end else if (drop && !s_axis_tlast) begin
                    // a lone mismatching tlast beat ends its own packet, nothing left to skip
                    state_nxt = DROP;
                end
            end
            DROP:   if (beat && s_axis_tlast) state_nxt = hvalid ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        pop           = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            STREAM:  s_axis_tready = !m_axis_tvalid || m_axis_tready;
            DROP:    s_axis_tready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset)      hvalid <= 1'b0;
        else if (pop)    hvalid <= 1'b1;
        else if (retire) hvalid <= 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hvfid <= '0;
            rem   <= '0;
        end else if (pop) begin
            hvfid <= fifo_vfid[rd_ptr];
            rem   <= fifo_beats[rd_ptr];
        end else if (fwd) begin
            rem   <= rem - 1'b1;
        end
    end

`ifdef BYPASS_RSP_KEEP_MASK_EN
    logic [OFF_BITS-1:0] fifo_lo [DEPTH];
    logic [OFF_BITS-1:0] hlo;
    logic [BPB-1:0]      keep_ones, tail_mask;

    always_ff @(posedge aclk) begin
        if (push) fifo_lo[wr_ptr] <= s_rq_len[OFF_BITS-1:0];
    end

    always_ff @(posedge aclk) begin
        if (areset)   hlo <= '0;
        else if (pop) hlo <= fifo_lo[rd_ptr];
    end

    assign keep_ones = '1;
    assign tail_mask = (hlo == '0) ? keep_ones : ~(keep_ones << hlo);
    assign keep_out  = last_beat ? tail_mask : s_axis_tkeep;
`else
    assign keep_out  = s_axis_tkeep;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (fwd) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= keep_out;
            m_axis_tlast  <= last_beat || s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt  <= '0;
            short_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != '1))       drop_cnt  <= drop_cnt + 32'd1;
            if (short_rsp && (short_cnt != '1)) short_cnt <= short_cnt + 32'd1;
        end
    end

    assign outstanding = count + CNT_BITS'(hvalid);

endmodule
